// File: rtl/spi_config_sequencer_pkg.sv
// Shared definitions for the SPI configuration sequencer: command word layout,
// SPI block State codes, error codes, table entry layout and sequencer states.
package spi_config_sequencer_pkg;

   localparam int CMD_PWR_BIT   = 31;
   localparam int CMD_START_BIT = 30;
   localparam int CMD_C_BIT     = 29;
   localparam int CMD_ADDR_MSB  = 28;
   localparam int CMD_ADDR_LSB  = 22;
   localparam int CMD_DATA_MSB  = 21;
   localparam int CMD_DATA_LSB  = 14;

   localparam logic [7:0] SPI_ST_INIT   = 8'd0;
   localparam logic [7:0] SPI_ST_IDLE_1 = 8'd3;
   localparam logic [7:0] SPI_ST_IDLE_2 = 8'd9;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_TIMEOUT = 2'd1,
      ERR_VERIFY  = 2'd2
   } err_code_e;

   typedef struct packed {
      logic       c;
      logic [6:0] addr;
      logic [7:0] data;
   } tbl_entry_t;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_PWR_UP,
      ST_FETCH,
      ST_LOAD,
      ST_ISSUE,
      ST_WAIT_DONE,
      ST_RELEASE,
      ST_CHECK,
      ST_NEXT,
      ST_FAIL,
      ST_PWR_DN
   } seq_state_e;

endpackage

// File: rtl/spi_wait_timer.sv
// Reloadable down-counter used to bound every wait on the SPI block State.
// expired_o is high in the last counting cycle of a window of CYCLES cycles.
module spi_wait_timer #(
   parameter int CYCLES = 4096
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic load_i,
   input  logic en_i,
   output logic expired_o
);
   localparam int W = $clog2(CYCLES + 1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = W'(CYCLES - 1);
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/spi_config_sequencer.sv
// Walks a register-write table through the SPI transmit block, optionally
// reading each write back and retrying on mismatch.
//
// state        | meaning
// IDLE         | waiting for go / pwr_off
// PWR_UP       | power_on set, waiting for SPI IDLE_1
// FETCH        | table address presented
// LOAD         | table data latched into the command fields
// ISSUE        | raise spi_start
// WAIT_DONE    | waiting for SPI IDLE_2, capture read-back compare
// RELEASE      | spi_start low, waiting for SPI IDLE_1
// CHECK        | decide verify read / retry / next / fail
// NEXT         | advance index or finish the run
// FAIL         | record failing index, end the run
// PWR_DN       | power_on cleared, waiting for SPI INIT
module spi_config_sequencer
   import spi_config_sequencer_pkg::*;
#(
   parameter int N_ENTRIES      = 16,
   parameter bit VERIFY         = 1'b1,
   parameter int MAX_RETRY      = 2,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic        FSM_CLK,
   input  logic        RES_N,
   input  logic        go,
   input  logic        pwr_off,
   output logic [7:0]  tbl_addr,
   input  logic [15:0] tbl_data,
   output logic [31:0] spi_cmd,
   input  logic [7:0]  spi_state,
   input  logic [7:0]  spi_rdata,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [1:0]  err_code,
   output logic [7:0]  err_index
);
   localparam logic [7:0] LAST_IDX = 8'(N_ENTRIES - 1);

   seq_state_e state_q, state_d;
   logic [7:0] idx_q, idx_d, retry_q, retry_d, err_index_q, err_index_d;
   logic       pwr_on_q, pwr_on_d, start_q, start_d, c_q, c_d;
   logic [6:0] addr_q, addr_d;
   logic [7:0] data_q, data_d;
   logic       vrd_q, vrd_d, match_q, match_d;
   logic       busy_q, busy_d, done_q, done_d, error_q, error_d;
   err_code_e  err_code_q, err_code_d;
   logic       tmr_en, tmr_expired;
   tbl_entry_t entry;

   assign entry  = tbl_entry_t'(tbl_data);
   assign tmr_en = (state_q == ST_PWR_UP) || (state_q == ST_WAIT_DONE) ||
                   (state_q == ST_RELEASE) || (state_q == ST_PWR_DN);

   spi_wait_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
      .clk_i     (FSM_CLK),
      .rst_n_i   (RES_N),
      .load_i    (state_d != state_q),
      .en_i      (tmr_en),
      .expired_o (tmr_expired)
   );

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      retry_d     = retry_q;
      err_index_d = err_index_q;
      pwr_on_d    = pwr_on_q;
      start_d     = start_q;
      c_d         = c_q;
      addr_d      = addr_q;
      data_d      = data_q;
      vrd_d       = vrd_q;
      match_d     = match_q;
      busy_d      = busy_q;
      done_d      = done_q;
      error_d     = error_q;
      err_code_d  = err_code_q;
      unique case (state_q)
         ST_IDLE: begin
            if (pwr_off) begin
               pwr_on_d   = 1'b0;
               done_d     = 1'b0;
               error_d    = 1'b0;
               err_code_d = ERR_NONE;
               state_d    = ST_PWR_DN;
            end else if (go) begin
               done_d     = 1'b0;
               error_d    = 1'b0;
               err_code_d = ERR_NONE;
               busy_d     = 1'b1;
               idx_d      = '0;
               retry_d    = '0;
               pwr_on_d   = 1'b1;
               state_d    = ST_PWR_UP;
            end
         end
         ST_PWR_UP: begin
            if (spi_state == SPI_ST_IDLE_1) begin
               state_d = ST_FETCH;
            end else if (tmr_expired) begin
               error_d    = 1'b1;
               err_code_d = ERR_TIMEOUT;
               state_d    = ST_FAIL;
            end
         end
         ST_FETCH: state_d = ST_LOAD;
         ST_LOAD: begin
            c_d     = entry.c;
            addr_d  = entry.addr;
            data_d  = entry.data;
            vrd_d   = 1'b0;
            state_d = ST_ISSUE;
         end
         ST_ISSUE: begin
            start_d = 1'b1;
            state_d = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            if (spi_state == SPI_ST_IDLE_2) begin
               match_d = (spi_rdata == data_q);
               start_d = 1'b0;
               state_d = ST_RELEASE;
            end else if (tmr_expired) begin
               start_d    = 1'b0;
               error_d    = 1'b1;
               err_code_d = ERR_TIMEOUT;
               state_d    = ST_FAIL;
            end
         end
         ST_RELEASE: begin
            if (spi_state == SPI_ST_IDLE_1) begin
               state_d = ST_CHECK;
            end else if (tmr_expired) begin
               error_d    = 1'b1;
               err_code_d = ERR_TIMEOUT;
               state_d    = ST_FAIL;
            end
         end
         ST_CHECK: begin
            // A write turns into a read of the same address; DATA_W keeps the expected value.
            if (VERIFY && c_q && !vrd_q) begin
               c_d     = 1'b0;
               vrd_d   = 1'b1;
               state_d = ST_ISSUE;
            end else if (vrd_q && match_q) begin
               retry_d = '0;
               state_d = ST_NEXT;
            end else if (vrd_q && (retry_q < 8'(MAX_RETRY))) begin
               retry_d = retry_q + 8'd1;
               c_d     = 1'b1;
               vrd_d   = 1'b0;
               state_d = ST_ISSUE;
            end else if (vrd_q) begin
               error_d    = 1'b1;
               err_code_d = ERR_VERIFY;
               state_d    = ST_FAIL;
            end else begin
               state_d = ST_NEXT;
            end
         end
         ST_NEXT: begin
            if (idx_q == LAST_IDX) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else begin
               idx_d   = idx_q + 8'd1;
               state_d = ST_FETCH;
            end
         end
         ST_FAIL: begin
            start_d     = 1'b0;
            busy_d      = 1'b0;
            err_index_d = idx_q;
            state_d     = ST_IDLE;
         end
         ST_PWR_DN: begin
            if (spi_state == SPI_ST_INIT) begin
               state_d = ST_IDLE;
            end else if (tmr_expired) begin
               error_d    = 1'b1;
               err_code_d = ERR_TIMEOUT;
               state_d    = ST_FAIL;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge FSM_CLK or negedge RES_N) begin
      if (!RES_N) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         retry_q     <= '0;
         err_index_q <= '0;
         pwr_on_q    <= 1'b0;
         start_q     <= 1'b0;
         c_q         <= 1'b0;
         addr_q      <= '0;
         data_q      <= '0;
         vrd_q       <= 1'b0;
         match_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         err_code_q  <= ERR_NONE;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         retry_q     <= retry_d;
         err_index_q <= err_index_d;
         pwr_on_q    <= pwr_on_d;
         start_q     <= start_d;
         c_q         <= c_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         vrd_q       <= vrd_d;
         match_q     <= match_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
         err_code_q  <= err_code_d;
      end
   end

   always_comb begin
      spi_cmd                             = '0;
      spi_cmd[CMD_PWR_BIT]                = pwr_on_q;
      spi_cmd[CMD_START_BIT]              = start_q;
      spi_cmd[CMD_C_BIT]                  = c_q;
      spi_cmd[CMD_ADDR_MSB:CMD_ADDR_LSB]  = addr_q;
      spi_cmd[CMD_DATA_MSB:CMD_DATA_LSB]  = data_q;
   end

   assign tbl_addr  = idx_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign error     = error_q;
   assign err_code  = err_code_q;
   assign err_index = err_index_q;

endmodule

// File: tb/tb_spi_config_sequencer.sv
// Two sequencer instances (writes-only and verify) driven against a behavioural
// SPI target and table memory; transactions are compared with a table-walk model.
module tb_spi_config_sequencer;
   localparam int N0  = 2;
   localparam int N1  = 4;
   localparam int MR  = 2;
   localparam int TMO = 4096;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n [2];
   logic        go [2];
   logic        off [2];
   logic [7:0]  taddr [2];
   logic [15:0] tdata [2];
   logic [31:0] cmd [2];
   logic [7:0]  st [2];
   logic [7:0]  rdata [2];
   logic        busy [2];
   logic        done [2];
   logic        error [2];
   logic [1:0]  ec [2];
   logic [7:0]  ei [2];

   spi_config_sequencer #(.N_ENTRIES(N0), .VERIFY(1'b0), .MAX_RETRY(MR), .TIMEOUT_CYCLES(TMO)) dut0 (
      .FSM_CLK(clk), .RES_N(rst_n[0]), .go(go[0]), .pwr_off(off[0]),
      .tbl_addr(taddr[0]), .tbl_data(tdata[0]), .spi_cmd(cmd[0]), .spi_state(st[0]),
      .spi_rdata(rdata[0]), .busy(busy[0]), .done(done[0]), .error(error[0]),
      .err_code(ec[0]), .err_index(ei[0]));

   spi_config_sequencer #(.N_ENTRIES(N1), .VERIFY(1'b1), .MAX_RETRY(MR), .TIMEOUT_CYCLES(TMO)) dut1 (
      .FSM_CLK(clk), .RES_N(rst_n[1]), .go(go[1]), .pwr_off(off[1]),
      .tbl_addr(taddr[1]), .tbl_data(tdata[1]), .spi_cmd(cmd[1]), .spi_state(st[1]),
      .spi_rdata(rdata[1]), .busy(busy[1]), .done(done[1]), .error(error[1]),
      .err_code(ec[1]), .err_index(ei[1]));

   // target behaviour: 0 honest, 1 reads always return 0, 2 hang after start
   int          mode [2];
   int          dly [2];
   logic [15:0] tbl [2][256];
   logic [7:0]  regf [2][128];
   logic [15:0] log0 [$];
   logic [15:0] log1 [$];

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         tdata[i] <= tbl[i][taddr[i]];
         if (!cmd[i][31]) begin
            if (st[i] != 8'd0) begin
               if (dly[i] > 0) dly[i] <= dly[i] - 1;
               else begin
                  st[i]  <= 8'd0;
                  dly[i] <= 3;
               end
            end
         end else begin
            case (st[i])
               8'd0: if (dly[i] > 0) dly[i] <= dly[i] - 1; else st[i] <= 8'd3;
               8'd3: begin
                  if (cmd[i][30]) begin
                     if (i == 0) log0.push_back(cmd[i][29:14]);
                     else        log1.push_back(cmd[i][29:14]);
                     st[i]  <= 8'd4;
                     dly[i] <= int'($urandom_range(1, 4));
                  end else dly[i] <= 6;
               end
               8'd4: begin
                  if (mode[i] != 2) begin
                     if (dly[i] > 0) dly[i] <= dly[i] - 1;
                     else begin
                        st[i] <= 8'd9;
                        if (cmd[i][29]) begin
                           regf[i][cmd[i][28:22]] <= cmd[i][21:14];
                           rdata[i] <= 8'h00;
                        end else begin
                           rdata[i] <= (mode[i] == 1) ? 8'h00 : regf[i][cmd[i][28:22]];
                        end
                     end
                  end
               end
               8'd9: if (!cmd[i][30]) st[i] <= 8'd3;
               default: st[i] <= 8'd0;
            endcase
         end
      end
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Expected transaction list from the table rules
   logic [15:0] exp_q [$];
   int          exp_err;
   int          exp_idx;

   task automatic build_ref(input int i, input int n, input bit verify, input bit stuck);
      logic [15:0] e;
      bit ok;
      exp_q.delete();
      exp_err = 0;
      exp_idx = 0;
      for (int k = 0; k < n; k++) begin
         e = tbl[i][k];
         if (!e[15] || !verify) exp_q.push_back(e);
         else begin
            ok = 1'b0;
            for (int r = 0; r <= MR && !ok; r++) begin
               exp_q.push_back(e);
               exp_q.push_back({1'b0, e[14:0]});
               ok = stuck ? (e[7:0] == 8'h00) : 1'b1;
            end
            if (!ok) begin
               exp_err = 2;
               exp_idx = k;
               return;
            end
         end
      end
   endtask

   task automatic cmp_log(input int i, input string tag);
      logic [15:0] got [$];
      if (i == 0) got = log0; else got = log1;
      chk({tag, "_len"}, got.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < got.size(); k++)
         chk($sformatf("%s_tx%0d", tag, k), got[k], exp_q[k]);
   endtask

   task automatic pulse(input int i, input logic g, input logic o);
      go[i]  = g;
      off[i] = o;
      @(negedge clk);
      go[i]  = 1'b0;
      off[i] = 1'b0;
   endtask

   task automatic wait_end(input int i, input int budget);
      int n = 0;
      while (!(done[i] || error[i]) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("wait_end%0d", i), n < budget, 1);
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_init(input int i);
      int n = 0;
      while (st[i] != 8'd0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("reach_init%0d", i), n < 200, 1);
      repeat (2) @(negedge clk);
   endtask

   task automatic rand_tbl(input int i, input int n);
      for (int k = 0; k < n; k++) tbl[i][k] = 16'($urandom);
   endtask

   initial begin
      int n;
      int k;
      logic [15:0] e;
      for (int i = 0; i < 2; i++) begin
         for (int a = 0; a < 256; a++) tbl[i][a] = 16'h0;
         for (int a = 0; a < 128; a++) regf[i][a] = 8'h0;
         mode[i] = 0; dly[i] = 3; st[i] = 8'd0; rdata[i] = 8'h0;
         go[i] = 1'b0; off[i] = 1'b0; rst_n[i] = 1'b0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("rst_cmd%0d", i), cmd[i], 32'h0);
         chk($sformatf("rst_flags%0d", i), {busy[i], done[i], error[i], ec[i]}, 32'h0);
         chk($sformatf("rst_addr_idx%0d", i), {taddr[i], ei[i]}, 32'h0);
      end
      rst_n[0] = 1'b1; rst_n[1] = 1'b1;
      repeat (2) @(negedge clk);

      // writes-only run with the fixed entries, go/pwr_off while busy ignored
      tbl[0][0] = 16'hA512; tbl[0][1] = 16'h8AFF; log0.delete();
      pulse(0, 1'b1, 1'b0);
      chk("t1_pwr_on", {cmd[0][31], busy[0]}, 2'b11);
      repeat (5) @(negedge clk);
      pulse(0, 1'b1, 1'b1);
      chk("t1_busy_ignore", {busy[0], cmd[0][31]}, 2'b11);
      wait_end(0, 2000);
      chk("t1_end", {busy[0], done[0], error[0]}, 3'b010);
      build_ref(0, N0, 1'b0, 1'b0);
      cmp_log(0, "t1");
      chk("t1_fields", (log0.size() == 2) ? {log0[0][14:0], log0[1][14:0]} : 32'hFFFF_FFFF,
          {7'h25, 8'h12, 7'h0A, 8'hFF});

      repeat (3) begin
         rand_tbl(0, N0); log0.delete();
         pulse(0, 1'b1, 1'b0);
         wait_end(0, 2000);
         chk("r0_end", {busy[0], done[0], error[0]}, 3'b010);
         build_ref(0, N0, 1'b0, 1'b0);
         cmp_log(0, "r0");
      end

      // power down after done; go during the power-down wait is ignored
      pulse(0, 1'b0, 1'b1);
      chk("pd_pwr_done", {cmd[0][31], done[0]}, 2'b00);
      pulse(0, 1'b1, 1'b0);
      chk("pd_go_ignored", {cmd[0][31], busy[0]}, 2'b00);
      wait_init(0);
      pulse(0, 1'b1, 1'b0);
      chk("pd_go_after", {cmd[0][31], busy[0]}, 2'b11);
      wait_end(0, 2000);
      chk("pd_run_end", {busy[0], done[0], error[0]}, 3'b010);
      pulse(0, 1'b1, 1'b1);
      chk("go_off_same", {cmd[0][31], busy[0], done[0]}, 3'b000);
      wait_init(0);

      // verify runs with an honest target
      tbl[1][0] = 16'hA512; rand_tbl(1, N1); tbl[1][0] = 16'hA512; log1.delete();
      pulse(1, 1'b1, 1'b0);
      wait_end(1, 4000);
      chk("v_end", {busy[1], done[1], error[1]}, 3'b010);
      build_ref(1, N1, 1'b1, 1'b0);
      cmp_log(1, "v");
      chk("v_wr_rd", (log1.size() >= 2) ? {log1[0], log1[1]} : 32'h0, {16'hA512, 16'h2512});
      repeat (2) begin
         rand_tbl(1, N1); log1.delete();
         pulse(1, 1'b1, 1'b0);
         wait_end(1, 4000);
         chk("vr_end", {busy[1], done[1], error[1]}, 3'b010);
         build_ref(1, N1, 1'b1, 1'b0);
         cmp_log(1, "vr");
      end

      // read-back always zero: retries then verify failure
      mode[1] = 1;
      rand_tbl(1, N1); tbl[1][0] = 16'hA512; log1.delete();
      pulse(1, 1'b1, 1'b0);
      wait_end(1, 4000);
      build_ref(1, N1, 1'b1, 1'b1);
      chk("vf_flags", {error[1], done[1], busy[1], cmd[1][31]}, 4'b1001);
      chk("vf_code_idx", {ec[1], ei[1]}, {2'd2, 8'd0});
      cmp_log(1, "vf");
      k = int'($urandom_range(1, 3));
      for (int j = 0; j < N1; j++) begin
         e = 16'($urandom);
         if (j < k && e[15]) e[7:0] = 8'h00;
         if (j == k) begin
            e[15] = 1'b1;
            if (e[7:0] == 8'h00) e[7:0] = 8'h5A;
         end
         tbl[1][j] = e;
      end
      log1.delete();
      pulse(1, 1'b1, 1'b0);
      wait_end(1, 6000);
      build_ref(1, N1, 1'b1, 1'b1);
      chk("vfr_flags", {error[1], done[1], busy[1], cmd[1][31]}, 4'b1001);
      chk("vfr_code_idx", {ec[1], ei[1]}, {exp_err[1:0], exp_idx[7:0]});
      cmp_log(1, "vfr");

      // target hangs after start: timeout
      mode[1] = 2;
      rand_tbl(1, N1);
      pulse(1, 1'b1, 1'b0);
      n = 0;
      while (!cmd[1][30] && n < 200) begin @(negedge clk); n++; end
      chk("to_start_seen", n < 200, 1);
      n = 0;
      while (cmd[1][30] && n < TMO + 100) begin n++; @(negedge clk); end
      chk("to_cycles", n, TMO);
      chk("to_err", {error[1], ec[1]}, 3'b101);
      repeat (2) @(negedge clk);
      chk("to_idx_busy", {ei[1], busy[1], cmd[1][31]}, {8'd0, 1'b0, 1'b1});
      mode[1] = 0;
      pulse(1, 1'b0, 1'b1);
      wait_init(1);

      // asynchronous reset in the middle of WAIT_DONE
      rand_tbl(1, N1);
      pulse(1, 1'b1, 1'b0);
      n = 0;
      while (st[1] != 8'd4 && n < 200) begin @(negedge clk); n++; end
      chk("rr_in_wait", {busy[1], cmd[1][30]}, 2'b11);
      #2 rst_n[1] = 1'b0;
      #1;
      chk("rr_cmd", cmd[1], 32'h0);
      chk("rr_busy", busy[1], 1'b0);
      @(negedge clk);
      rst_n[1] = 1'b1;
      wait_init(1);
      log1.delete();
      pulse(1, 1'b1, 1'b0);
      wait_end(1, 4000);
      build_ref(1, N1, 1'b1, 1'b0);
      chk("rr_recover", {busy[1], done[1], error[1]}, 3'b010);
      cmp_log(1, "rr");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
